// File: rtl/snoop_bus_scheduler.sv
// Snoop bus scheduler: round-robin arbitration between two L1 caches and
// sequencing of snoop -> L2 lookup -> dmem fill, with a timeout abort.
module snoop_bus_scheduler #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req1,
    input  logic [1:0]        op1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              req2,
    input  logic [1:0]        op2,
    input  logic [ADDR_W-1:0] addr2,
    output logic              gnt1,
    output logic              gnt2,
    output logic              done1,
    output logic              done2,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              snoop_valid1,
    output logic              snoop_valid2,
    output logic [1:0]        snoop_op,
    output logic [ADDR_W-1:0] snoop_addr,
    input  logic              snoop_hit1,
    input  logic              snoop_hit2,
    input  logic [DATA_W-1:0] snoop_data1,
    input  logic [DATA_W-1:0] snoop_data2,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic              l2_valid,
    input  logic              l2_hit,
    input  logic [DATA_W-1:0] l2_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    localparam logic [1:0] OP_UPGR = 2'b01;
    localparam logic [1:0] OP_NON  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNOOP,
        S_L2,
        S_MEM,
        S_RESP
    } state_t;

    // owner/last: 0 = core1, 1 = core2
    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q,  last_d;
    logic [1:0]        op_q,    op_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic              cand1, cand2, pick2;
    logic [CNT_W-1:0]  cnt_inc;
    logic              tmo;

    // Next-state, latch and data-capture logic for the transaction sequencer
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        cand1 = req1 && (op1 != OP_NON);
        cand2 = req2 && (op2 != OP_NON);
        // core2 wins when it is the only candidate, or both ask and core1 went last
        pick2 = cand2 && (!cand1 || !last_q);

        // saturating increment so the counter never wraps
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        tmo     = (cnt_inc == CNT_MAX);

        unique case (state_q)
            S_IDLE: begin
                if (cand1 || cand2) begin
                    owner_d = pick2;
                    op_d    = pick2 ? op2 : op1;
                    addr_d  = pick2 ? addr2 : addr1;
                    err_d   = 1'b0;
                    state_d = S_SNOOP;
                end
            end
            S_SNOOP: begin
                cnt_d = '0;
                if (op_q == OP_UPGR) begin
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (owner_q ? snoop_hit1 : snoop_hit2) begin
                    rdata_d = owner_q ? snoop_data1 : snoop_data2;
                    state_d = S_RESP;
                end else begin
                    state_d = S_L2;
                end
            end
            S_L2: begin
                cnt_d = cnt_inc;
                if (l2_valid) begin
                    if (l2_hit) begin
                        rdata_d = l2_data;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_MEM;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_MEM: begin
                cnt_d = cnt_inc;
                if (mem_ack) begin
                    rdata_d = mem_data;
                    state_d = S_RESP;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= OP_NON;
            addr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Moore output decode from registered state
    always_comb begin
        busy         = (state_q != S_IDLE);
        gnt1         = busy && !owner_q;
        gnt2         = busy && owner_q;
        done1        = (state_q == S_RESP) && !owner_q;
        done2        = (state_q == S_RESP) && owner_q;
        snoop_valid1 = (state_q == S_SNOOP) && owner_q;
        snoop_valid2 = (state_q == S_SNOOP) && !owner_q;
        snoop_op     = op_q;
        snoop_addr   = addr_q;
        l2_req       = (state_q == S_L2);
        l2_addr      = l2_req ? addr_q : '0;
        mem_req      = (state_q == S_MEM);
        mem_addr     = mem_req ? addr_q : '0;
        rdata        = rdata_q;
        err          = err_q;
    end

endmodule
